// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_MEM_BYTES = 128;
  localparam int unsigned LSU_ADDR_W    = 16;
  localparam int unsigned LSU_DATA_W    = 16;
  localparam int unsigned LSU_BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_RESP
  } lsu_state_e;

  // Request fields latched at acceptance (address is held separately: its width is a parameter)
  typedef struct packed {
    logic                  write;
    logic [LSU_DATA_W-1:0] data;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and byte-memory bus seen by the load/store unit.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
);

  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [ADDR_W-1:0]     ReqAddress;
  logic [LSU_DATA_W-1:0] ReqWriteData;
  logic                  RspValid;
  logic [LSU_DATA_W-1:0] RspReadData;
  logic                  RspError;
  logic [ADDR_W-1:0]     MemAddress;
  logic [LSU_BYTE_W-1:0] MemWriteByte;
  logic                  MemWrite;
  logic                  MemRead;
  logic [LSU_BYTE_W-1:0] MemReadByte;

  // Load/store unit side
  modport slave (
    input  ReqValid, ReqWrite, ReqAddress, ReqWriteData, MemReadByte,
    output ReqReady, RspValid, RspReadData, RspError,
    output MemAddress, MemWriteByte, MemWrite, MemRead
  );

  // CPU plus memory side
  modport master (
    output ReqValid, ReqWrite, ReqAddress, ReqWriteData, MemReadByte,
    input  ReqReady, RspValid, RspReadData, RspError,
    input  MemAddress, MemWriteByte, MemWrite, MemRead
  );

endinterface

// File: rtl/load_store_unit.sv
// Splits a big-endian 16-bit load/store into two byte accesses (high byte first)
// with a range check and a one-cycle completion pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = LSU_MEM_BYTES,
  parameter int unsigned ADDR_W    = LSU_ADDR_W
) (
  input logic               Clock,
  input logic               ResetN,
  load_store_unit_if.slave  bus
);

  // Highest legal start address: the word's second byte must still be in memory
  localparam logic [ADDR_W-1:0] LAST_START = ADDR_W'(MEM_BYTES - 2);

  lsu_state_e            state_q,     state_d;
  lsu_req_t              req_q,       req_d;
  logic [ADDR_W-1:0]     addr_q,      addr_d;
  logic [LSU_BYTE_W-1:0] hi_byte_q,   hi_byte_d;
  logic                  ready_q,     ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [LSU_DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
  logic [LSU_BYTE_W-1:0] mem_wbyte_q, mem_wbyte_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q,  mem_read_d;

  logic in_range_c;
  assign in_range_c = (bus.ReqAddress <= LAST_START);

  // Next state, request capture and response formation
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    hi_byte_d  = hi_byte_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.ReqValid) begin
          req_d  = '{write: bus.ReqWrite, data: bus.ReqWriteData};
          addr_d = bus.ReqAddress;
          if (in_range_c) begin
            state_d = ST_HI;
          end else begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      ST_HI: begin
        if (!req_q.write) hi_byte_d = bus.MemReadByte;
        state_d = ST_LO;
      end
      ST_LO: begin
        state_d    = ST_RESP;
        rsp_err_d  = 1'b0;
        rsp_data_d = req_q.write ? '0 : {hi_byte_q, bus.MemReadByte};
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they leave the flops aligned with it
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    mem_addr_d  = '0;
    mem_wbyte_d = '0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;

    case (state_d)
      ST_HI: begin
        mem_addr_d  = addr_d;
        mem_write_d = req_d.write;
        mem_read_d  = !req_d.write;
        if (req_d.write) mem_wbyte_d = req_d.data[15:8];
      end
      ST_LO: begin
        mem_addr_d  = addr_d + ADDR_W'(1);
        mem_write_d = req_d.write;
        mem_read_d  = !req_d.write;
        if (req_d.write) mem_wbyte_d = req_d.data[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      addr_q      <= '0;
      hi_byte_q   <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wbyte_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      hi_byte_q   <= hi_byte_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wbyte_q <= mem_wbyte_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign bus.ReqReady     = ready_q;
  assign bus.RspValid     = rsp_valid_q;
  assign bus.RspReadData  = rsp_data_q;
  assign bus.RspError     = rsp_err_q;
  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemWriteByte = mem_wbyte_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.MemRead      = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte memory model, response scoreboard,
// strobe/address checks, range boundary, held requests and reset abort.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic Clock  = 1'b0;
  logic ResetN = 1'b1;
  always #5 Clock = ~Clock;

  load_store_unit_if #(.ADDR_W(16)) bus();

  load_store_unit #(.MEM_BYTES(128), .ADDR_W(16)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  logic [7:0] mem    [128];
  logic [7:0] shadow [128];

  assign bus.MemReadByte = mem[bus.MemAddress[6:0]];
  always @(posedge Clock) if (bus.MemWrite) mem[bus.MemAddress[6:0]] = bus.MemWriteByte;

  typedef struct packed { logic [15:0] data; logic err; } exp_t;
  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; any response is matched against the oldest scoreboard entry
  task automatic step();
    exp_t e;
    @(posedge Clock);
    #1;
    if (bus.RspValid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(bus.RspValid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 32'(bus.RspReadData), 32'(e.data));
        check("rsp_err",  32'(bus.RspError),    32'(e.err));
      end
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic expect_rsp);
    exp_t e;
    logic ok;
    logic [6:0] i0, i1;
    ok = (a <= 16'd126);
    i0 = a[6:0];
    i1 = i0 + 7'd1;
    check("req_ready", 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.ReqAddress = a; bus.ReqWriteData = d;
    if (expect_rsp) begin
      e.err  = !ok;
      e.data = (wr || !ok) ? 16'h0000 : {shadow[i0], shadow[i1]};
      sb.push_back(e);
      if (wr && ok) begin
        shadow[i0] = d[15:8];
        shadow[i1] = d[7:0];
      end
    end
    step();
    bus.ReqValid = 1'b0; bus.ReqWrite = ~wr; bus.ReqAddress = ~a; bus.ReqWriteData = ~d;
  endtask

  initial begin
    logic [15:0] a;
    exp_t e;
    logic acc;
    for (int i = 0; i < 128; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    mem[7]   = 8'h12; shadow[7]   = 8'h12;
    mem[8]   = 8'h34; shadow[8]   = 8'h34;
    mem[126] = 8'hC3; shadow[126] = 8'hC3;
    mem[127] = 8'h3C; shadow[127] = 8'h3C;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqAddress = '0; bus.ReqWriteData = '0;

    #3 ResetN = 1'b0;
    #10;
    check("rst_ready",  32'(bus.ReqReady),     32'd1);
    check("rst_valid",  32'(bus.RspValid),     32'd0);
    check("rst_err",    32'(bus.RspError),     32'd0);
    check("rst_rdata",  32'(bus.RspReadData),  32'd0);
    check("rst_mwrite", 32'(bus.MemWrite),     32'd0);
    check("rst_mread",  32'(bus.MemRead),      32'd0);
    check("rst_maddr",  32'(bus.MemAddress),   32'd0);
    check("rst_mbyte",  32'(bus.MemWriteByte), 32'd0);
    @(negedge Clock) ResetN = 1'b1;
    step();

    // Store 0xA55A @0x0010
    issue(1'b1, 16'h0010, 16'hA55A, 1'b1);
    check("st_hi_addr",  32'(bus.MemAddress),   32'h0010);
    check("st_hi_write", 32'(bus.MemWrite),     32'd1);
    check("st_hi_read",  32'(bus.MemRead),      32'd0);
    check("st_hi_byte",  32'(bus.MemWriteByte), 32'hA5);
    check("st_busy",     32'(bus.ReqReady),     32'd0);
    step();
    check("st_lo_addr",  32'(bus.MemAddress),   32'h0011);
    check("st_lo_write", 32'(bus.MemWrite),     32'd1);
    check("st_lo_byte",  32'(bus.MemWriteByte), 32'h5A);
    step();
    check("st_rsp_valid", 32'(bus.RspValid), 32'd1);
    check("st_rsp_nowr",  32'(bus.MemWrite), 32'd0);
    check("st_rsp_addr",  32'(bus.MemAddress), 32'd0);
    step();
    check("st_done_valid", 32'(bus.RspValid), 32'd0);
    check("mem10", 32'(mem[16]), 32'hA5);
    check("mem11", 32'(mem[17]), 32'h5A);

    // Load @0x0010, then unaligned @0x0007
    issue(1'b0, 16'h0010, 16'h0000, 1'b1);
    check("ld_hi_read", 32'(bus.MemRead),    32'd1);
    check("ld_hi_addr", 32'(bus.MemAddress), 32'h0010);
    step();
    check("ld_lo_read", 32'(bus.MemRead),    32'd1);
    check("ld_lo_addr", 32'(bus.MemAddress), 32'h0011);
    step(); step();
    issue(1'b0, 16'h0007, 16'h0000, 1'b1);
    step(); step(); step();

    // Range boundary: 0x007F errors in one cycle, 0x007E is legal
    issue(1'b0, 16'h007F, 16'h0000, 1'b1);
    check("oor_valid", 32'(bus.RspValid), 32'd1);
    check("oor_read",  32'(bus.MemRead),  32'd0);
    check("oor_write", 32'(bus.MemWrite), 32'd0);
    step();
    check("oor_valid_low", 32'(bus.RspValid), 32'd0);
    check("oor_err_hold",  32'(bus.RspError), 32'd1);
    check("oor_ready",     32'(bus.ReqReady), 32'd1);
    issue(1'b0, 16'h007E, 16'h0000, 1'b1);
    check("edge_hi_addr", 32'(bus.MemAddress), 32'h007E);
    step();
    check("edge_lo_addr", 32'(bus.MemAddress), 32'h007F);
    step();
    check("rdata_hold_pre", 32'(bus.RspReadData), 32'hC33C);
    step();
    check("rdata_hold", 32'(bus.RspReadData), 32'hC33C);
    issue(1'b1, 16'hFFFF, 16'h1234, 1'b1);
    check("oor_st_write", 32'(bus.MemWrite), 32'd0);
    step();

    // Held ReqValid with a new (even) address every cycle
    for (int k = 0; k < 12; k++) begin
      a = 16'h0020 + 16'(2 * k);
      bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAddress = a;
      if (k % 4 == 0) begin
        e.err  = 1'b0;
        e.data = {shadow[a[6:0]], shadow[a[6:0] + 7'd1]};
        sb.push_back(e);
      end
      step();
      acc = bus.MemRead && (bus.MemAddress == a);
      check($sformatf("held_accept_%0d", k), 32'(acc), 32'((k % 4) == 0));
    end
    bus.ReqValid = 1'b0;
    step();

    // Reset in the LO cycle of store 0xBEEF @0x0020 aborts it
    issue(1'b1, 16'h0020, 16'hBEEF, 1'b0);
    check("ab_hi_byte", 32'(bus.MemWriteByte), 32'hBE);
    step();
    check("ab_lo_write", 32'(bus.MemWrite), 32'd1);
    #2 ResetN = 1'b0;
    #1;
    check("ab_ready",  32'(bus.ReqReady),     32'd1);
    check("ab_write",  32'(bus.MemWrite),     32'd0);
    check("ab_read",   32'(bus.MemRead),      32'd0);
    check("ab_addr",   32'(bus.MemAddress),   32'd0);
    check("ab_byte",   32'(bus.MemWriteByte), 32'd0);
    check("ab_valid",  32'(bus.RspValid),     32'd0);
    check("ab_rdata",  32'(bus.RspReadData),  32'd0);
    step();
    shadow[32] = 8'hBE;
    check("ab_mem20", 32'(mem[32]), 32'(shadow[32]));
    check("ab_mem21", 32'(mem[33]), 32'(shadow[33]));
    @(negedge Clock) ResetN = 1'b1;
    step();
    issue(1'b0, 16'h0020, 16'h0000, 1'b1);
    step(); step(); step(); step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
